// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: program counter, instruction register and req/ack memory fetch
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_req,
    input  logic              im_ack,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic              next,
    input  logic              br_taken,
    input  logic              br_abs,
    input  logic [15:0]       imm,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_HALT
    } state_t;

    // Immediate is widened to at least 16 bits before narrowing so ADDR_W < 16 truncates cleanly.
    localparam int EXT_W = (ADDR_W > 16) ? ADDR_W : 16;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] pcNext;
    logic [DATA_W-1:0] irNext;
    logic              irValidNext;

    logic [EXT_W-1:0]  immZeroWide;
    logic [EXT_W-1:0]  immSignWide;
    logic [ADDR_W-1:0] immZext;
    logic [ADDR_W-1:0] immSext;
    logic [ADDR_W-1:0] seqPc;
    logic [ADDR_W-1:0] targetPc;

    assign immZeroWide = EXT_W'(imm);
    assign immSignWide = EXT_W'($signed(imm));
    assign immZext     = immZeroWide[ADDR_W-1:0];
    assign immSext     = immSignWide[ADDR_W-1:0];
    assign seqPc       = pc + ADDR_W'(1);

    always_comb begin
        targetPc = seqPc;
        if (br_taken) begin
            if (br_abs) begin
                targetPc = immZext;
            end else begin
                targetPc = seqPc + immSext;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        irNext      = ir;
        irValidNext = ir_valid;
        case (state)
            S_IDLE: begin
                stateNext = S_REQ;
            end
            S_REQ: begin
                if (im_ack) begin
                    irNext      = im_rdata;
                    irValidNext = 1'b1;
                    stateNext   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (next) begin
                    irValidNext = 1'b0;
                    if (halt) begin
                        stateNext = S_HALT;
                    end else begin
                        pcNext    = targetPc;
                        stateNext = S_REQ;
                    end
                end
            end
            S_HALT: begin
                irValidNext = 1'b0;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            ir       <= irNext;
            ir_valid <= irValidNext;
        end
    end

    assign im_req  = (state == S_REQ);
    assign im_addr = pc;
    assign busy    = (state != S_HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst_f;
    logic [15:0] im_addr;
    logic        im_req;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        next;
    logic        br_taken;
    logic        br_abs;
    logic [15:0] imm;
    logic        halt;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        busy;

    int checks;
    int errors;

    fetch_unit #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .im_addr  (im_addr),
        .im_req   (im_req),
        .im_ack   (im_ack),
        .im_rdata (im_rdata),
        .next     (next),
        .br_taken (br_taken),
        .br_abs   (br_abs),
        .imm      (imm),
        .halt     (halt),
        .pc       (pc),
        .ir       (ir),
        .ir_valid (ir_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rstF;
        logic        ack;
        logic [31:0] rdata;
        logic        nxt;
        logic        brT;
        logic        brA;
        logic [15:0] immV;
        logic        hlt;
        logic [15:0] expPc;
        logic [31:0] expIr;
        logic        expValid;
        logic        expReq;
        logic        expBusy;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic [31:0] d, input logic n,
                         input logic bt, input logic ba, input logic [15:0] iv, input logic h);
        im_ack   = a;
        im_rdata = d;
        next     = n;
        br_taken = bt;
        br_abs   = ba;
        imm      = iv;
        halt     = h;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [15:0] ePc, input logic [31:0] eIr,
                              input logic eValid, input logic eReq, input logic eBusy);
        check({tag, ".pc"},       32'(pc),       32'(ePc));
        check({tag, ".im_addr"},  32'(im_addr),  32'(ePc));
        check({tag, ".ir"},       ir,            eIr);
        check({tag, ".ir_valid"}, 32'(ir_valid), 32'(eValid));
        check({tag, ".im_req"},   32'(im_req),   32'(eReq));
        check({tag, ".busy"},     32'(busy),     32'(eBusy));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_f    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        //           rst  ack rdata          nxt  brT  brA  imm     hlt   pc      ir             v    req  busy
        vecs[0]  = '{1'b0,1'b0,32'h00000000,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,32'h00000000,1'b0,1'b0,1'b1};
        vecs[1]  = '{1'b1,1'b0,32'h00000000,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,32'h00000000,1'b0,1'b1,1'b1};
        vecs[2]  = '{1'b1,1'b1,32'h11230001,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,32'h11230001,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,32'h11230001,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,32'h00000000,1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0001,32'h11230001,1'b0,1'b1,1'b1};
        vecs[5]  = '{1'b1,1'b0,32'h00000000,1'b1,1'b1,1'b1,16'h0040,1'b1,16'h0001,32'h11230001,1'b0,1'b1,1'b1};
        vecs[6]  = '{1'b1,1'b1,32'h00000005,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0001,32'h00000005,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,32'h00000000,1'b1,1'b1,1'b1,16'h0005,1'b0,16'h0005,32'h00000005,1'b0,1'b1,1'b1};
        vecs[8]  = '{1'b1,1'b1,32'hAAAA0001,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0005,32'hAAAA0001,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,32'h00000000,1'b1,1'b1,1'b0,16'hFFFD,1'b0,16'h0003,32'hAAAA0001,1'b0,1'b1,1'b1};
        vecs[10] = '{1'b1,1'b1,32'hBBBB0002,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0003,32'hBBBB0002,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,32'h00000000,1'b1,1'b1,1'b1,16'h0010,1'b0,16'h0010,32'hBBBB0002,1'b0,1'b1,1'b1};
        vecs[12] = '{1'b1,1'b1,32'hCCCC0003,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0010,32'hCCCC0003,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,32'h00000000,1'b1,1'b1,1'b1,16'hFFFF,1'b0,16'hFFFF,32'hCCCC0003,1'b0,1'b1,1'b1};
        vecs[14] = '{1'b1,1'b1,32'hDDDD0004,1'b0,1'b0,1'b0,16'h0000,1'b0,16'hFFFF,32'hDDDD0004,1'b1,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,32'h00000000,1'b1,1'b0,1'b1,16'h1234,1'b0,16'h0000,32'hDDDD0004,1'b0,1'b1,1'b1};
        vecs[16] = '{1'b1,1'b1,32'hEEEE0005,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,32'hEEEE0005,1'b1,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b0,32'h00000000,1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0001,32'hEEEE0005,1'b0,1'b1,1'b1};
        vecs[18] = '{1'b1,1'b1,32'hFFFF0006,1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0001,32'hFFFF0006,1'b1,1'b0,1'b0};
        vecs[19] = '{1'b1,1'b0,32'h00000000,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0001,32'hFFFF0006,1'b1,1'b0,1'b0};
        vecs[20] = '{1'b1,1'b0,32'h00000000,1'b1,1'b1,1'b0,16'hFFFD,1'b0,16'hFFFF,32'hFFFF0006,1'b0,1'b1,1'b1};
        vecs[21] = '{1'b1,1'b1,32'h12345678,1'b0,1'b0,1'b0,16'h0000,1'b0,16'hFFFF,32'h12345678,1'b1,1'b0,1'b0};
        vecs[22] = '{1'b1,1'b0,32'h00000000,1'b1,1'b1,1'b0,16'h0002,1'b0,16'h0002,32'h12345678,1'b0,1'b1,1'b1};
        vecs[23] = '{1'b1,1'b1,32'h13579BDF,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0002,32'h13579BDF,1'b1,1'b0,1'b0};

        for (int i = 0; i < 24; i++) begin
            rst_f = vecs[i].rstF;
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].nxt, vecs[i].brT, vecs[i].brA,
                  vecs[i].immV, vecs[i].hlt);
            step();
            checkState($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expIr,
                       vecs[i].expValid, vecs[i].expReq, vecs[i].expBusy);
        end

        // Slow memory: ack arrives on the third S_REQ cycle.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        checkState("slow.c1", 16'h0003, 32'h13579BDF, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 32'h77777777, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        checkState("slow.c2", 16'h0003, 32'h13579BDF, 1'b0, 1'b1, 1'b1);
        step();
        checkState("slow.c3", 16'h0003, 32'h13579BDF, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h00000055, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        checkState("slow.ack", 16'h0003, 32'h00000055, 1'b1, 1'b0, 1'b0);

        // Reset while waiting for ack; a late ack after release must be ignored.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        checkState("rst.req", 16'h0004, 32'h00000055, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        #2;
        rst_f = 1'b0;
        #1;
        checkState("rst.async", 16'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        step();
        checkState("rst.held", 16'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1);
        rst_f = 1'b1;
        drive(1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        checkState("rst.lateack", 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        checkState("rst.wait", 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h11230001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        checkState("rst.fetch", 16'h0000, 32'h11230001, 1'b1, 1'b0, 1'b0);

        // Halt is terminal: nothing fetches or changes for 20 cycles.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0007, 1'b1);
        step();
        checkState("halt.enter", 16'h0000, 32'h11230001, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 1'b0);
            step();
            checkState($sformatf("halt.c%0d", c), 16'h0000, 32'h11230001, 1'b0, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the SISC datapath.
- Owns the program counter and the instruction register; drives the 32-bit ir bus consumed by the sisc core.
- Fetches from an external instruction memory over a req/ack handshake that tolerates variable latency.
- Advances sequentially or to a branch target when the control unit signals that the current instruction has retired.

Parameters:
- ADDR_W, 16, program counter and instruction-memory address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_f  input  1  asynchronous, active-low reset.
- im_addr  output  ADDR_W  instruction memory address; combinationally equal to pc.
- im_req  output  1  fetch request to instruction memory.
- im_ack  input  1  memory response valid; im_rdata is valid in the same cycle.
- im_rdata  input  DATA_W  instruction word from memory.
- next  input  1  single-cycle pulse from ctrl: current instruction retired.
- br_taken  input  1  branch taken; sampled only when next=1.
- br_abs  input  1  1 = absolute target (imm), 0 = PC-relative target; sampled only when next=1.
- imm  input  16  branch offset or target; in practice ir[15:0].
- halt  input  1  stop fetching; sampled only when next=1.
- pc  output  ADDR_W  current program counter.
- ir  output  DATA_W  instruction register; feeds the sisc ir input.
- ir_valid  output  1  ir holds a fetched, unretired instruction.
- busy  output  1  high in every state except S_HOLD.

Behaviour:
- Reset (rst_f=0, asynchronous):
  - state=S_IDLE, pc=RESET_PC, ir=0, ir_valid=0, im_req=0.
  - Takes effect immediately, including mid-fetch. An in-flight request is abandoned, and an im_ack arriving after reset is ignored.
- States:
  - S_IDLE: im_req=0. Always goes to S_REQ on the next edge. This gives one dead cycle after reset release.
  - S_REQ: im_req=1, im_addr=pc. On the edge where im_ack=1: ir<=im_rdata, ir_valid<=1, go to S_HOLD. Otherwise stay, with im_req held high.
  - S_HOLD: im_req=0; ir and pc are stable.
    - On next=1 with halt=1: ir_valid<=0, go to S_HALT; pc is unchanged.
    - On next=1 with halt=0: update pc, ir_valid<=0, go to S_REQ.
  - S_HALT: im_req=0, ir_valid=0. Terminal state until reset; ir keeps its last value.
- PC update (S_HOLD with next=1 and halt=0):
  - br_taken=0: pc <= pc+1.
  - br_taken=1, br_abs=1: pc <= imm, zero-extended or truncated to ADDR_W.
  - br_taken=1, br_abs=0: pc <= pc + 1 + sign_extend(imm).
  - All arithmetic is modulo 2^ADDR_W; wrap-around is silent (0xFFFF+1 -> 0x0000).
- Latency:
  - Zero-wait memory (ack in the first S_REQ cycle): ir_valid rises 1 cycle after entering S_REQ.
  - Next-to-new-ir minimum: 2 edges (S_HOLD->S_REQ, then S_REQ->S_HOLD).
  - After reset release: first ir_valid on the 2nd rising edge with zero-wait memory.
- Ignored inputs:
  - im_ack in any state other than S_REQ.
  - next, br_taken, br_abs and halt in any state other than S_HOLD.
  - next held high for multiple cycles advances only once per S_HOLD visit.
- im_rdata is captured only on im_ack in S_REQ; ir never changes in S_HOLD or S_HALT.
- busy = (state != S_HOLD), combinational.

Test Plan:
- Reset then zero-wait memory returning 0x11230001 at addr 0 -> im_req high at cycle 1, ir=0x11230001 and ir_valid=1 after edge 2, pc=0.
- Memory with 3-cycle ack latency -> im_req stays high and im_addr stable for 3 cycles, ir unchanged until ack, ir_valid rises on the ack edge.
- pc=0x0005, next with br_taken=1, br_abs=0, imm=0xFFFD -> pc=0x0003. Same with imm=0x0010 and br_abs=1 -> pc=0x0010.
- pc=0xFFFF, next with br_taken=0 -> pc=0x0000, im_addr=0x0000, no error.
- Stray im_ack pulses in S_HOLD, and next pulses during S_REQ -> ir and pc unchanged, state unchanged.
- rst_f dropped during the S_REQ wait, late im_ack delivered one cycle after release -> pc=RESET_PC, ir=0, ir_valid=0, ack ignored. Separately: next with halt=1 -> S_HALT, im_req stays 0 for 20 cycles.
